// File: rtl/memory_arbiter_pkg.sv
// Shared types and defaults for the instruction/data memory arbiter.
// Holds the FSM state enum, the owner enum and default parameter values.
package memory_arbiter_pkg;

   localparam int DEF_DATA_WIDTH   = 32;
   localparam int DEF_STARVE_LIMIT = 4;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } state_t;

   typedef enum logic {
      OWN_IF = 1'b0,
      OWN_LS = 1'b1
   } owner_t;

endpackage

// File: rtl/memory_arbiter_starve_counter.sv
// Saturating count of data-port grants made while a fetch waits.
// Ports: clk, rst_n, i_if_req, i_if_gnt, i_ls_gnt in; o_if_prio out.
module arbiter_starve_counter #(
   parameter int STARVE_LIMIT = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_if_req,
   input  logic i_if_gnt,
   input  logic i_ls_gnt,
   output logic o_if_prio
);

   localparam int CW = $clog2(STARVE_LIMIT + 1);
   localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

   logic [CW-1:0] r_cnt;
   logic          w_sat;

   assign w_sat     = (r_cnt == LIMIT);
   assign o_if_prio = w_sat;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (!i_if_req || i_if_gnt) begin
         r_cnt <= '0;
      end else if (i_ls_gnt && !w_sat) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/memory_arbiter.sv
// Arbitrates fetch and load/store ports onto one memory, 3 cycles/txn.
// Ports: if_* fetch port, ls_* load/store port, mem_* shared memory.
module memory_arbiter
   import memory_arbiter_pkg::*;
#(
   parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
   parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  if_req_i,
   input  logic [DATA_WIDTH-1:0] if_addr_i,
   output logic                  if_gnt_o,
   output logic                  if_valid_o,
   output logic [DATA_WIDTH-1:0] if_rdata_o,
   input  logic                  ls_req_i,
   input  logic                  ls_we_i,
   input  logic [DATA_WIDTH-1:0] ls_addr_i,
   input  logic [DATA_WIDTH-1:0] ls_wdata_i,
   output logic                  ls_gnt_o,
   output logic                  ls_valid_o,
   output logic [DATA_WIDTH-1:0] ls_rdata_o,
   output logic [DATA_WIDTH-1:0] mem_addr_o,
   output logic                  mem_we_o,
   output logic [DATA_WIDTH-1:0] mem_wdata_o,
   input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

   state_t                r_state;
   state_t                w_next;
   owner_t                r_owner;
   logic                  r_we;
   logic [DATA_WIDTH-1:0] r_addr;
   logic [DATA_WIDTH-1:0] r_wdata;
   logic [DATA_WIDTH-1:0] r_if_rdata;
   logic [DATA_WIDTH-1:0] r_ls_rdata;
   logic                  w_idle;
   logic                  w_if_prio;
   logic                  w_if_gnt;
   logic                  w_ls_gnt;

   // Grants are combinational; rst_n gating keeps them quiet in reset.
   assign w_idle   = (r_state == IDLE) && rst_n;
   assign w_if_gnt = w_idle && if_req_i && (!ls_req_i || w_if_prio);
   assign w_ls_gnt = w_idle && ls_req_i && !w_if_gnt;

   arbiter_starve_counter #(
      .STARVE_LIMIT (STARVE_LIMIT)
   ) u_starve (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_if_req  (if_req_i),
      .i_if_gnt  (w_if_gnt),
      .i_ls_gnt  (w_ls_gnt),
      .o_if_prio (w_if_prio)
   );

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         IDLE:    if (w_if_gnt || w_ls_gnt) w_next = ACCESS;
         ACCESS:  w_next = DONE;
         DONE:    w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_owner <= OWN_IF;
         r_we    <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
      end else if (w_ls_gnt) begin
         r_owner <= OWN_LS;
         r_we    <= ls_we_i;
         r_addr  <= ls_addr_i;
         r_wdata <= ls_wdata_i;
      end else if (w_if_gnt) begin
         r_owner <= OWN_IF;
         r_we    <= 1'b0;
         r_addr  <= if_addr_i;
      end
   end

   // Read data lands on the ACCESS->DONE edge; stores leave it alone.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_if_rdata <= '0;
         r_ls_rdata <= '0;
      end else if (r_state == ACCESS && !r_we) begin
         if (r_owner == OWN_IF) r_if_rdata <= mem_rdata_i;
         else                   r_ls_rdata <= mem_rdata_i;
      end
   end

   assign if_gnt_o    = w_if_gnt;
   assign ls_gnt_o    = w_ls_gnt;
   assign if_valid_o  = (r_state == DONE) && (r_owner == OWN_IF);
   assign ls_valid_o  = (r_state == DONE) && (r_owner == OWN_LS);
   assign if_rdata_o  = r_if_rdata;
   assign ls_rdata_o  = r_ls_rdata;
   assign mem_addr_o  = r_addr;
   assign mem_wdata_o = r_wdata;
   assign mem_we_o    = (r_state == ACCESS) && r_we;

endmodule
